// File: rtl/button_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, debounce FSM, and one-cycle
// press / release / long-press event pulses, all registered in the CLK domain.
module button_debounce #(
    parameter int DEBOUNCE_COUNT   = 1_000_000,
    parameter int LONG_PRESS_COUNT = 100_000_000,
    parameter bit ACTIVE_LOW       = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int DEB_W  = (DEBOUNCE_COUNT < 1) ? 1 : $clog2(DEBOUNCE_COUNT + 1);
    localparam int HOLD_W = (LONG_PRESS_COUNT == 0) ? 1 : $clog2(LONG_PRESS_COUNT + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_COUNT - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_ZERO  = DEB_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((LONG_PRESS_COUNT == 0) ? 0 : LONG_PRESS_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};
    localparam bit                LONG_EN   = (LONG_PRESS_COUNT != 0);

    typedef enum logic [1:0] {
        S_RELEASED        = 2'd0,
        S_PRESS_PENDING   = 2'd1,
        S_PRESSED         = 2'd2,
        S_RELEASE_PENDING = 2'd3
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    state_t            r_state;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_fired;
    logic              r_pressed;
    logic              r_press_pulse;
    logic              r_release_pulse;
    logic              r_long_pulse;
    logic              w_active;

    assign w_active = r_sync2 ^ ACTIVE_LOW;

    // Two-flop synchronizer on the raw pin, parked at the idle pin level in reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce state machine with registered level and event pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state         <= S_RELEASED;
            r_deb_cnt       <= DEB_ZERO;
            r_hold_cnt      <= HOLD_ZERO;
            r_fired         <= 1'b0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            case (r_state)
                S_RELEASED: begin
                    if (w_active) begin
                        r_state   <= S_PRESS_PENDING;
                        r_deb_cnt <= DEB_ZERO;
                    end else begin
                        r_state <= S_RELEASED;
                    end
                end
                S_PRESS_PENDING: begin
                    if (!w_active) begin
                        r_state <= S_RELEASED;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state       <= S_PRESSED;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_hold_cnt    <= HOLD_ZERO;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_ONE;
                    end
                end
                S_PRESSED: begin
                    if (!w_active) begin
                        r_state   <= S_RELEASE_PENDING;
                        r_deb_cnt <= DEB_ZERO;
                    end else if (LONG_EN && !r_fired && (r_hold_cnt == HOLD_LAST)) begin
                        r_long_pulse <= 1'b1;
                        r_fired      <= 1'b1;
                    end else if (!r_fired && (r_hold_cnt != HOLD_MAX)) begin
                        // Saturating so a disabled long-press never wraps the hold counter
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt;
                    end
                end
                S_RELEASE_PENDING: begin
                    // Hold count and fired flag survive a bounce back to PRESSED
                    if (w_active) begin
                        r_state <= S_PRESSED;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state         <= S_RELEASED;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                        r_hold_cnt      <= HOLD_ZERO;
                        r_fired         <= 1'b0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_ONE;
                    end
                end
                default: begin
                    r_state   <= S_RELEASED;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign pressed          = r_pressed;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_pulse;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: an active-low and an active-high instance
// share CLK/RST; expected output nibbles are queued per cycle and popped after each edge.
module tb_button_debounce;

    localparam logic [3:0] E_IDLE  = 4'b0000;
    localparam logic [3:0] E_HELD  = 4'b1000;
    localparam logic [3:0] E_PRESS = 4'b1100;
    localparam logic [3:0] E_REL   = 4'b0010;
    localparam logic [3:0] E_LONG  = 4'b1001;

    logic clk;
    logic rst;
    logic btn_a;
    logic btn_b;
    logic a_pressed, a_press, a_release, a_long;
    logic b_pressed, b_press, b_release, b_long;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    button_debounce #(
        .DEBOUNCE_COUNT  (4),
        .LONG_PRESS_COUNT(20),
        .ACTIVE_LOW      (1'b1)
    ) u_dut_al (
        .CLK             (clk),
        .RST             (rst),
        .BTN             (btn_a),
        .pressed         (a_pressed),
        .press_pulse     (a_press),
        .release_pulse   (a_release),
        .long_press_pulse(a_long)
    );

    button_debounce #(
        .DEBOUNCE_COUNT  (4),
        .LONG_PRESS_COUNT(20),
        .ACTIVE_LOW      (1'b0)
    ) u_dut_ah (
        .CLK             (clk),
        .RST             (rst),
        .BTN             (btn_b),
        .pressed         (b_pressed),
        .press_pulse     (b_press),
        .release_pulse   (b_release),
        .long_press_pulse(b_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_pop(input string tag);
        logic [7:0] e;
        logic [3:0] obs_a;
        logic [3:0] obs_b;
        obs_a = {a_pressed, a_press, a_release, a_long};
        obs_b = {b_pressed, b_press, b_release, b_long};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed a=%b b=%b", tag, obs_a, obs_b);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (obs_a === e[7:4]) else begin
                errors++;
                $error("FAIL %s_al: observed=%b expected=%b", tag, obs_a, e[7:4]);
            end
            checks++;
            assert (obs_b === e[3:0]) else begin
                errors++;
                $error("FAIL %s_ah: observed=%b expected=%b", tag, obs_b, e[3:0]);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic ba, input logic bb,
                       input logic [3:0] ea, input logic [3:0] eb);
        btn_a = ba;
        btn_b = bb;
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #2;
        check_pop(tag);
    endtask

    task automatic seg(input string tag, input logic ba, input logic bb, input int n,
                       input logic [3:0] ea, input logic [3:0] eb);
        for (int i = 0; i < n; i++) begin
            cyc(tag, ba, bb, ea, eb);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        btn_a = 1'b1;
        btn_b = 1'b0;
        #3;
        exp_q.push_back({E_IDLE, E_IDLE});
        check_pop("reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        seg("idle", 1'b1, 1'b0, 5, E_IDLE, E_IDLE);

        // Clean press: pressed after edge 7
        seg("s1_pend", 1'b0, 1'b0, 6, E_IDLE, E_IDLE);
        cyc("s1_rise", 1'b0, 1'b0, E_PRESS, E_IDLE);
        seg("s1_hold", 1'b0, 1'b0, 5, E_HELD, E_IDLE);

        // Release bounce: high 2, low 2, then high held
        seg("s3_bhi", 1'b1, 1'b0, 2, E_HELD, E_IDLE);
        seg("s3_blo", 1'b0, 1'b0, 2, E_HELD, E_IDLE);
        seg("s3_pend", 1'b1, 1'b0, 6, E_HELD, E_IDLE);
        cyc("s3_fall", 1'b1, 1'b0, E_REL, E_IDLE);
        seg("s3_idle", 1'b1, 1'b0, 4, E_IDLE, E_IDLE);

        // Press bounce: low 3, high 2, low 3, high
        seg("s2_lo1", 1'b0, 1'b0, 3, E_IDLE, E_IDLE);
        seg("s2_hi1", 1'b1, 1'b0, 2, E_IDLE, E_IDLE);
        seg("s2_lo2", 1'b0, 1'b0, 3, E_IDLE, E_IDLE);
        seg("s2_hi2", 1'b1, 1'b0, 6, E_IDLE, E_IDLE);

        // Long press, bounce back into PRESSED without refire, release
        seg("s4_pend", 1'b0, 1'b0, 6, E_IDLE, E_IDLE);
        cyc("s4_rise", 1'b0, 1'b0, E_PRESS, E_IDLE);
        seg("s4_hold", 1'b0, 1'b0, 19, E_HELD, E_IDLE);
        cyc("s4_long", 1'b0, 1'b0, E_LONG, E_IDLE);
        seg("s4_hold2", 1'b0, 1'b0, 40, E_HELD, E_IDLE);
        seg("s4_bhi", 1'b1, 1'b0, 2, E_HELD, E_IDLE);
        seg("s4_norefire", 1'b0, 1'b0, 30, E_HELD, E_IDLE);
        seg("s4_rpend", 1'b1, 1'b0, 6, E_HELD, E_IDLE);
        cyc("s4_fall", 1'b1, 1'b0, E_REL, E_IDLE);
        seg("s4_idle", 1'b1, 1'b0, 4, E_IDLE, E_IDLE);
        seg("s4_pend2", 1'b0, 1'b0, 6, E_IDLE, E_IDLE);
        cyc("s4_rise2", 1'b0, 1'b0, E_PRESS, E_IDLE);
        seg("s4_hold3", 1'b0, 1'b0, 19, E_HELD, E_IDLE);
        cyc("s4_long2", 1'b0, 1'b0, E_LONG, E_IDLE);
        seg("s4_hold4", 1'b0, 1'b0, 5, E_HELD, E_IDLE);
        seg("s4_rpend2", 1'b1, 1'b0, 6, E_HELD, E_IDLE);
        cyc("s4_fall2", 1'b1, 1'b0, E_REL, E_IDLE);
        seg("s4_idle2", 1'b1, 1'b0, 4, E_IDLE, E_IDLE);

        // Reset while held: outputs clear without a clock edge, then a fresh press
        seg("s5_pend", 1'b0, 1'b0, 6, E_IDLE, E_IDLE);
        cyc("s5_rise", 1'b0, 1'b0, E_PRESS, E_IDLE);
        seg("s5_hold", 1'b0, 1'b0, 3, E_HELD, E_IDLE);
        rst = 1'b1;
        #1;
        exp_q.push_back({E_IDLE, E_IDLE});
        check_pop("s5_async");
        cyc("s5_inrst", 1'b0, 1'b0, E_IDLE, E_IDLE);
        rst = 1'b0;
        seg("s5_pend2", 1'b0, 1'b0, 6, E_IDLE, E_IDLE);
        cyc("s5_rise2", 1'b0, 1'b0, E_PRESS, E_IDLE);
        seg("s5_hold2", 1'b0, 1'b0, 3, E_HELD, E_IDLE);
        seg("s5_rpend", 1'b1, 1'b0, 6, E_HELD, E_IDLE);
        cyc("s5_fall", 1'b1, 1'b0, E_REL, E_IDLE);
        seg("s5_idle", 1'b1, 1'b0, 2, E_IDLE, E_IDLE);

        // Active-high instance: same timing with inverted pin
        seg("s6_pend", 1'b1, 1'b1, 6, E_IDLE, E_IDLE);
        cyc("s6_rise", 1'b1, 1'b1, E_IDLE, E_PRESS);
        seg("s6_hold", 1'b1, 1'b1, 5, E_IDLE, E_HELD);
        seg("s6_rpend", 1'b1, 1'b0, 6, E_IDLE, E_HELD);
        cyc("s6_fall", 1'b1, 1'b0, E_IDLE, E_REL);
        seg("s6_idle", 1'b1, 1'b0, 3, E_IDLE, E_IDLE);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed=%0d expected=0 pending entries", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
